vga_capture: RTL
================

# vga_capture

Receive-side counterpart to the VGA output path: samples a 640x480@60 VGA stream (12-bit RGB plus active-low hsync/vsync, one pixel per clk_i) and writes a 4x-decimated 160x120 image into an external 19200-entry framebuffer RAM. It recovers pixel/line position from the sync edges, qualifies lock over a full frame, and emits writes only while locked. Sits between a VGA source (screensaver loopback or external capture front end) and a dual-port image RAM.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- clk_i  input  1  pixel clock; one sample per cycle
- rst_ni  input  1  reset, asynchronous assert, active-low
- vga_red_i / vga_green_i / vga_blue_i  input  4 each  pixel colour
- vga_hsync_i  input  1  horizontal sync, active-low
- vga_vsync_i  input  1  vertical sync, active-low
- we_o  output  1  framebuffer write enable
- waddr_o  output  15  framebuffer address, (y>>2)*160 + (x>>2)
- wdata_o  output  12  {red, green, blue}
- locked_o  output  1  timing lock status
- frame_done_o  output  1  one-cycle pulse after last write of a frame
- frame_sum_o  output  16  frame checksum (see Configuration)

## Operation
- All inputs registered once (stage S1); previous S1 sync values kept for edge detection.
- h_cnt 0..799 (H total), v_cnt 0..524 (V total); h_cnt free-runs and wraps 799->0; v_cnt increments on h_cnt wrap, wraps 524->0.
- Sync anchors: sample where hsync first reads low has x = H_ACTIVE+H_FP = 656; line where vsync first reads low has y = V_ACTIVE+V_FP = 490, with vsync fall aligned to x=0.
- States:
  - SEARCH: wait for vsync falling edge; load v_cnt=490 -> ALIGN. Counters loaded on every hsync fall (h_cnt=656).
  - ALIGN: hsync fall with predicted h_cnt != 656 -> reload, set mismatch flag. Next vsync fall: predicted v_cnt==490 and no mismatch -> LOCKED; otherwise reload, clear flag, stay ALIGN.
  - LOCKED: hsync fall at h_cnt != 656 or vsync fall at v_cnt != 490 -> SEARCH.
- Write rule: in LOCKED, when x<640, y<480, x[1:0]==0, y[1:0]==0 -> we_o=1, waddr_o=(y[8:2])*160+x[9:2], wdata_o=S1 colour. 19200 writes per frame, addresses strictly increasing 0..19199.
- frame_done_o pulses the cycle after the write to address 19199, only in LOCKED.
- locked_o = (state==LOCKED).

## Timing
- Reset: state SEARCH; we_o=0, waddr_o=0, wdata_o=0, locked_o=0, frame_done_o=0, frame_sum_o=0; counters 0.
- Latency: pixel on input at cycle N -> write on we_o/waddr_o/wdata_o at cycle N+2 (S1 + output register).
- Loss of lock: offending sync edge in S1 at cycle N -> locked_o low at N+1; no write at or after N+1 until relock. A frame interrupted by lock loss gets no frame_done_o.
- Relock requires vsync fall (enter ALIGN) plus one full clean frame; earliest LOCKED at second vsync fall.
- hsync and vsync falling in the same sample: both anchors applied (x=656 line y=490 is invalid for standard timing -> treated as a mismatch in ALIGN/LOCKED).
- Reset mid-frame: outputs zero immediately (async), resume in SEARCH.
- we_o high at most 1 cycle in every 4; no backpressure, RAM must accept every write.

## Configuration
- VGA_CAPTURE_CHECKSUM_EN defined: 16-bit accumulator adds zero-extended wdata_o (mod 2^16) on each write of a frame; cleared at frame start (y=0,x=0 write); frame_sum_o updated to the final sum in the same cycle frame_done_o pulses, held otherwise.
- Not defined: accumulator absent, frame_sum_o tied to 0; port still present.

## Test plan
- Reset: drive rst_ni low mid-stream -> all outputs 0 within same cycle, locked_o stays 0 for first frame after release.
- Solid 0xF0A stream from standard 640x480 generator -> locked_o rises at second vsync fall; next frame exactly 19200 writes, addresses 0..19199 in order, wdata 0xF0A, one frame_done_o.
- Pattern colour = {x[5:2], y[5:2], 4'h0} -> write at addr a holds {(a%160)[3:0], (a/160)[3:0], 0}; write appears 2 cycles after sample.
- One line shortened to 799 clocks while LOCKED -> locked_o low next cycle, no writes, no frame_done_o; relock after next vsync plus one clean frame.
- Checksum (macro on): constant 0x001 -> frame_sum_o=0x4B00; constant 0xFFF -> 0xB500. Macro off: frame_sum_o=0 always.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: recovers 640x480@60 pixel/line position from VGA sync edges and writes a 4x-decimated image to a framebuffer.
// Latency: pixel on the input pins at cycle N appears on we_o/waddr_o/wdata_o at cycle N+2.
// Backpressure: none; we_o is high at most one cycle in four and the RAM must accept every write.
// Optional feature VGA_CAPTURE_CHECKSUM_EN: per-frame 16-bit sum of written pixels on frame_sum_o (tied to 0 otherwise).
module vga_capture #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  vga_red_i,
   input  logic [3:0]  vga_green_i,
   input  logic [3:0]  vga_blue_i,
   input  logic        vga_hsync_i,
   input  logic        vga_vsync_i,
   output logic        we_o,
   output logic [14:0] waddr_o,
   output logic [11:0] wdata_o,
   output logic        locked_o,
   output logic        frame_done_o,
   output logic [15:0] frame_sum_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sync anchors: first hsync-low sample and first vsync-low line (at x=0)
   localparam logic [9:0]  H_ANCHOR  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  V_ANCHOR  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
   localparam logic [14:0] LINE_W    = 15'(H_ACTIVE / 4);
   localparam logic [14:0] LAST_ADDR = 15'((H_ACTIVE / 4) * (V_ACTIVE / 4) - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        mismatch;
   logic        mismatch_nxt;

   logic [11:0] pix_s1;
   logic        hs_s1;
   logic        vs_s1;
   logic        hs_prev;
   logic        vs_prev;
   logic        hs_fall;
   logic        vs_fall;
   logic        hs_bad;
   logic        vs_bad;

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;

   logic        wr_c;
   logic [14:0] addr_c;
   logic [14:0] row_base;
   logic        done_c;

   // Register the raw VGA inputs; keep the previous sync sample for falling-edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pix_s1  <= '0;
         hs_s1   <= 1'b1;
         vs_s1   <= 1'b1;
         hs_prev <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         pix_s1  <= {vga_red_i, vga_green_i, vga_blue_i};
         hs_s1   <= vga_hsync_i;
         vs_s1   <= vga_vsync_i;
         hs_prev <= hs_s1;
         vs_prev <= vs_s1;
      end
   end

   assign hs_fall = hs_prev & ~hs_s1;
   assign vs_fall = vs_prev & ~vs_s1;

   // A sync edge disagrees with the predicted position; coincident edges can never be valid timing
   assign hs_bad = hs_fall && (vs_fall || (h_cnt != H_ANCHOR));
   assign vs_bad = vs_fall && (hs_fall || (v_cnt != V_ANCHOR));

   // Position counters describe the S1 sample; every sync fall re-anchors them, which is a no-op when aligned
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (vs_fall && hs_fall) begin
         h_cnt <= H_ANCHOR + 10'd1;
         v_cnt <= V_ANCHOR;
      end else if (vs_fall) begin
         h_cnt <= 10'd1;
         v_cnt <= V_ANCHOR;
      end else if (hs_fall) begin
         h_cnt <= H_ANCHOR + 10'd1;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // Lock state register and per-frame mismatch flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_SEARCH;
         mismatch <= 1'b0;
      end else begin
         state    <= state_nxt;
         mismatch <= mismatch_nxt;
      end
   end

   // Lock qualification: a full frame between two vsync falls must see only expected sync edges
   always_comb begin
      state_nxt    = state;
      mismatch_nxt = mismatch;
      case (state)
         ST_SEARCH: begin
            if (vs_fall) begin
               state_nxt    = ST_ALIGN;
               mismatch_nxt = hs_fall;
            end
         end
         ST_ALIGN: begin
            if (vs_fall) begin
               if (!vs_bad && !mismatch) begin
                  state_nxt = ST_LOCKED;
               end
               mismatch_nxt = hs_fall;
            end else if (hs_bad) begin
               mismatch_nxt = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (hs_bad || vs_bad) begin
               state_nxt = ST_SEARCH;
            end
         end
         default: begin
            state_nxt    = ST_SEARCH;
            mismatch_nxt = 1'b0;
         end
      endcase
   end

   // Write decision for the S1 sample; an offending edge in this sample already suppresses it
   always_comb begin
      wr_c     = 1'b0;
      row_base = {8'd0, v_cnt[8:2]} * LINE_W;
      addr_c   = row_base + {7'd0, h_cnt[9:2]};
      if ((state == ST_LOCKED) && !hs_bad && !vs_bad &&
          (h_cnt < H_ACT) && (v_cnt < V_ACT) &&
          (h_cnt[1:0] == 2'b00) && (v_cnt[1:0] == 2'b00)) begin
         wr_c = 1'b1;
      end
   end

   // Framebuffer write port register; address and data hold between writes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         we_o <= wr_c;
         if (wr_c) begin
            waddr_o <= addr_c;
            wdata_o <= pix_s1;
         end
      end
   end

   // Frame completes when the last address was just written and lock survives into the next cycle
   assign done_c = we_o && (waddr_o == LAST_ADDR) && (state_nxt == ST_LOCKED);

   // One-cycle frame completion pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= done_c;
      end
   end

   assign locked_o = (state == ST_LOCKED);

`ifdef VGA_CAPTURE_CHECKSUM_EN
   logic [15:0] sum_acc;

   // Accumulate every written pixel; the first write of a frame (address 0) restarts the sum
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_acc <= '0;
      end else if (wr_c) begin
         sum_acc <= ((addr_c == 15'd0) ? 16'd0 : sum_acc) + {4'd0, pix_s1};
      end
   end

   // Publish the completed sum in the same cycle as frame_done_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_sum_o <= '0;
      end else if (done_c) begin
         frame_sum_o <= sum_acc;
      end
   end
`else
   assign frame_sum_o = '0;
`endif

endmodule
